// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter sharing the UART TX FIFO write port among NREQ producers.
// Define TX_ARB_TIMEOUT_EN to compile in revocation of a grant whose owner stalls for TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              uart_clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  input  logic              tf_full,
  output logic              tf_wrreq,
  output logic [7:0]        tf_data,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              timeout_evt
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   owner_nxt;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   rr_ptr_nxt;
  logic [NREQ-1:0] grant_nxt;

  logic            own_valid;
  logic            own_last;
  logic [7:0]      own_data;
  logic            accept;
  logic            release_last;
  logic            gap_expire;
  logic            pick_found;
  logic [PW-1:0]   pick_idx;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] idx);
    if (idx == PW'(NREQ - 1)) return '0;
    return idx + PW'(1);
  endfunction

  // Rotate the valid vector so bit 0 is rr_ptr, then the lowest set bit is the winner.
  function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] vld,
                                          input logic [PW-1:0]   ptr);
    logic [2*NREQ-1:0] dbl;
    logic [PW:0]       pos;
    logic [PW:0]       res;
    dbl = {vld, vld} >> ptr;
    pos = '0;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (dbl[k]) begin
        pos = {1'b0, ptr} + (PW+1)'(k);
        if (pos >= (PW+1)'(NREQ)) pos = pos - (PW+1)'(NREQ);
        res = {1'b1, pos[PW-1:0]};
      end
    end
    return res;
  endfunction

  assign {pick_found, pick_idx} = rr_pick(req_valid, rr_ptr);

  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == PW'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_data  = req_data[8*i +: 8];
      end
    end
  end

  // Write path is combinational so the owner's byte lands in the FIFO the same cycle.
  assign busy         = (state == XFER);
  assign accept       = busy & own_valid & ~tf_full;
  assign release_last = accept & own_last;
  assign tf_wrreq     = accept;
  assign tf_data      = accept ? own_data : 8'h00;
  assign req_ready    = (busy && !tf_full) ? grant : '0;

`ifdef TX_ARB_TIMEOUT_EN
  logic [15:0] gap_cnt;
  logic [15:0] gap_cnt_nxt;

  // Full-FIFO cycles are stalls on our side, not the producer's, so they hold the count.
  always_comb begin
    gap_cnt_nxt = gap_cnt;
    gap_expire  = 1'b0;
    if (!busy || own_valid) begin
      gap_cnt_nxt = '0;
    end else if (!tf_full) begin
      if (({1'b0, gap_cnt} + 17'd1) == 17'(TIMEOUT)) begin
        gap_expire  = 1'b1;
        gap_cnt_nxt = '0;
      end else begin
        gap_cnt_nxt = gap_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge uart_clk) begin
    if (!rst_n) begin
      gap_cnt     <= '0;
      timeout_evt <= 1'b0;
    end else begin
      gap_cnt     <= gap_cnt_nxt;
      timeout_evt <= gap_expire;
    end
  end
`else
  assign gap_expire  = 1'b0;
  assign timeout_evt = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    grant_nxt  = grant;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt = XFER;
          owner_nxt = pick_idx;
          grant_nxt = NREQ'(1) << pick_idx;
        end
      end
      XFER: begin
        if (release_last || gap_expire) begin
          state_nxt  = IDLE;
          grant_nxt  = '0;
          rr_ptr_nxt = wrap_inc(owner);
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge uart_clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      grant  <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_ptr_nxt;
      grant  <= grant_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic against a message-level model.
// Compile with TX_ARB_TIMEOUT_EN defined to exercise the grant-revocation build.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 4;

  logic           uart_clk = 1'b0;
  logic           rst_n    = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data  = '0;
  logic [N-1:0]   req_last  = '0;
  logic [N-1:0]   req_ready;
  logic           tf_full = 1'b0;
  logic           tf_wrreq;
  logic [7:0]     tf_data;
  logic [N-1:0]   grant;
  logic           busy;
  logic           timeout_evt;

  always #5 uart_clk = ~uart_clk;

  uart_tx_arbiter #(.NREQ(N), .TIMEOUT(TO)) dut (
    .uart_clk(uart_clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tf_full(tf_full), .tf_wrreq(tf_wrreq),
    .tf_data(tf_data), .grant(grant), .busy(busy), .timeout_evt(timeout_evt)
  );

  int errors = 0;
  int checks = 0;

  // Producer byte queues: {last, data}
  logic [8:0] qbuf [N][256];
  int qh [N];
  int qt [N];
  logic [N-1:0] hold = '0;

  // Reference model state: owner (-1 idle), round-robin pointer, gap count, pending event
  int m_owner = -1;
  int m_ptr   = 0;
  int m_gap   = 0;
  bit m_evt   = 1'b0;

  // Observed FIFO writes and timeout pulses
  int wlog_own [64];
  int wlog_dat [64];
  int wn = 0;
  int evt_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input int r, input logic [7:0] d, input bit last);
    qbuf[r][qt[r] % 256] = {last, d};
    qt[r]++;
  endtask

  task automatic push_msg(input int r, input int len);
    for (int b = 0; b < len; b++) push_byte(r, 8'($urandom), b == len - 1);
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin
      qh[i] = 0;
      qt[i] = 0;
    end
    hold    = '0;
    wn      = 0;
    evt_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      wlog_own[i] = -1;
      wlog_dat[i] = -1;
    end
  endtask

  task automatic step(input bit rst_lo, input bit full);
    logic [N-1:0] v;
    logic [N-1:0] eg;
    logic [N-1:0] er;
    logic         ew;
    logic [7:0]   ed;
    logic [8:0]   front;
    bit           found;
    @(negedge uart_clk);
    rst_n   = !rst_lo;
    tf_full = full;
    for (int i = 0; i < N; i++) begin
      if (qh[i] != qt[i] && !hold[i]) begin
        req_valid[i] = 1'b1;
        {req_last[i], req_data[8*i +: 8]} = qbuf[i][qh[i] % 256];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[8*i +: 8]  = 8'($urandom);
        req_last[i]         = 1'($urandom);
      end
    end
    v = req_valid;
    #1;
    front = (m_owner >= 0) ? qbuf[m_owner][qh[m_owner] % 256] : 9'h0;
    eg = (m_owner >= 0) ? N'(1) << m_owner : '0;
    er = (m_owner >= 0 && !full) ? eg : '0;
    ew = (m_owner >= 0) && v[m_owner] && !full;
    ed = ew ? front[7:0] : 8'h00;
    chk("grant", 32'(grant), 32'(eg));
    chk("busy", 32'(busy), 32'(m_owner >= 0));
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("tf_wrreq", 32'(tf_wrreq), 32'(ew));
    chk("tf_data", 32'(tf_data), 32'(ed));
    chk("timeout_evt", 32'(timeout_evt), 32'(m_evt));
    if (tf_wrreq && wn < 64) begin
      for (int i = 0; i < N; i++) if (grant[i]) wlog_own[wn] = i;
      wlog_dat[wn] = int'(tf_data);
      wn++;
    end
    if (timeout_evt) evt_cnt++;
    if (ew) qh[m_owner]++;
    // Model advance to the state seen after the coming rising edge
    m_evt = 1'b0;
    if (rst_lo) begin
      m_owner = -1;
      m_ptr   = 0;
      m_gap   = 0;
    end else if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (!found && v[j]) begin
          found   = 1'b1;
          m_owner = j;
        end
      end
      m_gap = 0;
    end else if (ew && front[8]) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
      m_gap   = 0;
    end
`ifdef TX_ARB_TIMEOUT_EN
    else if (v[m_owner]) begin
      m_gap = 0;
    end else if (!full) begin
      m_gap++;
      if (m_gap == TO) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_gap   = 0;
        m_evt   = 1'b1;
      end
    end
`endif
  endtask

  task automatic steps(input int n, input bit full);
    for (int i = 0; i < n; i++) step(1'b0, full);
  endtask

  task automatic restart();
    clear_all();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
  endtask

  initial begin
    int outstanding;

    // Reset state and single requester 2
    restart();
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_wrreq", 32'(tf_wrreq), 32'h0);
    push_byte(2, 8'h41, 1'b0);
    push_byte(2, 8'h42, 1'b1);
    steps(4, 1'b0);
    chk("single_count", 32'(wn), 32'd2);
    chk("single_d0", 32'(wlog_dat[0]), 32'h41);
    chk("single_d1", 32'(wlog_dat[1]), 32'h42);
    chk("single_own", 32'(wlog_own[1]), 32'd2);
    for (int i = 0; i < N; i++) push_byte(i, 8'(8'h60 + i), 1'b1);
    steps(12, 1'b0);
    chk("ptr3_first", 32'(wlog_own[2]), 32'd3);
    chk("ptr3_wrap", 32'(wlog_own[3]), 32'd0);

    // All four requesters, two-byte messages
    restart();
    for (int i = 0; i < N; i++) begin
      push_byte(i, 8'(8'h10 * (i + 1) + 1), 1'b0);
      push_byte(i, 8'(8'h10 * (i + 1) + 2), 1'b1);
    end
    steps(14, 1'b0);
    chk("all4_count", 32'(wn), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("all4_own", 32'(wlog_own[i]), 32'(i / 2));
      chk("all4_dat", 32'(wlog_dat[i]), 32'(8'h10 * (i / 2 + 1) + (i % 2) + 1));
    end

    // FIFO full for 5 cycles mid-message from requester 1
    restart();
    push_byte(1, 8'hB1, 1'b0);
    push_byte(1, 8'hB2, 1'b0);
    push_byte(1, 8'hB3, 1'b1);
    steps(2, 1'b0);
    steps(5, 1'b1);
    steps(4, 1'b0);
    chk("full_count", 32'(wn), 32'd3);
    chk("full_d1", 32'(wlog_dat[1]), 32'hB2);
    chk("full_d2", 32'(wlog_dat[2]), 32'hB3);

    // Owner 0 goes quiet for 10 cycles while requester 1 waits
    restart();
    push_byte(0, 8'h11, 1'b0);
    push_byte(0, 8'h55, 1'b1);
    push_byte(1, 8'hA1, 1'b0);
    push_byte(1, 8'hA2, 1'b1);
    steps(2, 1'b0);
    hold[0] = 1'b1;
    steps(10, 1'b0);
    hold[0] = 1'b0;
    steps(8, 1'b0);
    chk("gap_count", 32'(wn), 32'd4);
    chk("gap_d0", 32'(wlog_dat[0]), 32'h11);
`ifdef TX_ARB_TIMEOUT_EN
    chk("gap_evt", 32'(evt_cnt), 32'd1);
    chk("gap_d1", 32'(wlog_dat[1]), 32'hA1);
    chk("gap_d3", 32'(wlog_dat[3]), 32'h55);
`else
    chk("gap_evt", 32'(evt_cnt), 32'd0);
    chk("gap_d1", 32'(wlog_dat[1]), 32'h55);
    chk("gap_d3", 32'(wlog_dat[3]), 32'hA2);
`endif

    // Reset in the middle of requester 3's message
    restart();
    for (int b = 0; b < 4; b++) push_byte(3, 8'(8'hC1 + b), b == 3);
    steps(3, 1'b0);
    push_byte(0, 8'hD1, 1'b0);
    push_byte(0, 8'hD2, 1'b1);
    step(1'b1, 1'b0);
    wn = 0;
    step(1'b0, 1'b0);
    chk("rst_mid_grant", 32'(grant), 32'h0);
    chk("rst_mid_wrreq", 32'(tf_wrreq), 32'h0);
    steps(6, 1'b0);
    chk("rst_mid_first", 32'(wlog_own[0]), 32'd0);
    chk("rst_mid_dat", 32'(wlog_dat[0]), 32'hD1);

    // Random traffic, gaps, stalls and occasional resets
    restart();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(31) == 0 && (qt[i] - qh[i]) < 200) push_msg(i, int'($urandom_range(4, 1)));
        hold[i] = ($urandom_range(4) == 0);
      end
      step($urandom_range(699) == 0, $urandom_range(3) == 0);
    end
    hold = '0;
    steps(600, 1'b0);
    outstanding = 0;
    for (int i = 0; i < N; i++) outstanding += qt[i] - qh[i];
    chk("drain", 32'(outstanding), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin, message-locked arbiter that shares the single UART transmit FIFO write port among `NREQ` byte producers. It sits between the producers and the TX FIFO that feeds the UART transmitter, in the `uart_clk` domain. It grants one requester at a time and holds that grant until the requester's `last` byte is written, so bytes from different messages never interleave on the line.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 255: idle-gap cycles before a stalled grant is revoked, 1..65535. Used only with `TX_ARB_TIMEOUT_EN`.
- `uart_clk`, in, 1: sole clock; all logic on the rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `req_valid`, in, NREQ: per-requester byte valid.
- `req_data`, in, 8*NREQ: requester i byte on bits [8i+7:8i].
- `req_last`, in, NREQ: current byte is the final byte of the message.
- `req_ready`, out, NREQ: byte accepted this cycle when `req_valid[i]` and `req_ready[i]` are both high.
- `tf_full`, in, 1: TX FIFO full.
- `tf_wrreq`, out, 1: TX FIFO write strobe.
- `tf_data`, out, 8: TX FIFO write data.
- `grant`, out, NREQ: one-hot current owner, registered; all zeros when idle.
- `busy`, out, 1: high while in XFER.
- `timeout_evt`, out, 1: one-cycle pulse when a grant is revoked by timeout.

## Operation
- FSM states:
  - IDLE: `grant` = 0; `req_ready` = 0.
  - XFER: `grant` holds the one-hot owner g.
- Arbitration from IDLE:
  - If any `req_valid` bit is high, pick the first i with `req_valid[i]`, searching from `rr_ptr` upward modulo NREQ.
  - Next cycle: `grant[i]` = 1, state = XFER.
  - No valid requests: stay in IDLE.
  - Valid bits are sampled only in IDLE; a requester that drops valid before the grant registers is still granted.
- In XFER:
  - `req_ready[g]` = `~tf_full`; every other ready bit is 0.
  - `tf_wrreq` = `req_valid[g] & ~tf_full`; `tf_data` = `req_data[g]`. This path is combinational, zero latency.
  - `tf_data` = 0 whenever `tf_wrreq` = 0.
- Release: on an accepted beat with `req_last[g]` = 1, the next state is IDLE, `grant` is cleared, and `rr_ptr` = (g+1) mod NREQ.
- Gaps in `req_valid[g]` during XFER do not release the grant, except by timeout when enabled.
- `req_last` on a non-granted requester, or on a non-accepted beat, is ignored.
- `rr_ptr` width is clog2(NREQ), min 1; the wrap from NREQ-1 goes to 0.

## Timing
- Reset (`rst_n` low at a clock edge): state = IDLE, `grant` = 0, `rr_ptr` = 0, timeout counter = 0, `busy` = 0, `timeout_evt` = 0. With state IDLE, `req_ready`, `tf_wrreq` and `tf_data` are all 0.
- Reset mid-message drops the grant immediately. The partial message is not completed; that is the producer's responsibility.
- Request to first write: request seen in IDLE at cycle N, grant at N+1, first `tf_wrreq` at N+1 if `tf_full` = 0.
- There is exactly one IDLE cycle between consecutive messages, which gives a minimum 1-cycle bubble.
- `tf_full` stall:
  - Ready stays low and nothing is written or lost.
  - The granted byte must be held by the producer.
  - Stall cycles do not count toward the timeout.
- A single-byte message (valid and last together) takes 1 XFER cycle.
- Back-to-back requests from all requesters are served in ptr order; a requester waits at most NREQ-1 messages.

## Configuration
- `TX_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter runs in XFER. It increments on cycles with `req_valid[g]` = 0 and resets on any cycle with `req_valid[g]` = 1 or on leaving XFER.
  - When the count reaches `TIMEOUT`: release as on last, `rr_ptr` = g+1, `timeout_evt` = 1 for exactly one cycle.
- Undefined: no counter; `timeout_evt` is tied to 0; the grant is held until last.

## Test plan
- Reset then single requester: `req_valid[2]` with bytes 0x41, 0x42 (last) -> `grant` = 0100 one cycle later, `tf_wrreq` two cycles, `tf_data` 0x41 then 0x42, then IDLE with `rr_ptr` = 3.
- All four valid, each sending a 2-byte message, after reset -> grant order 0, 1, 2, 3, no interleaving, one IDLE cycle between messages.
- `tf_full` held high 5 cycles mid-message from req 1 -> `req_ready[1]` = 0 and `tf_wrreq` = 0 for those 5 cycles, the next byte is written the cycle `tf_full` drops, no byte duplicated or lost.
- Granted req 0 drops valid for 10 cycles, then sends 0x55 (last) with the macro off -> grant held throughout, 0x55 written, other requests wait.
- Same stimulus with `TX_ARB_TIMEOUT_EN` and `TIMEOUT` = 4 -> `timeout_evt` pulses 4 gap cycles after valid drops, grant moves to the next valid requester, and 0x55 is not accepted from req 0 until it is re-granted.
- `rst_n` low for 1 cycle during req 3's message -> `grant` = 0 and `tf_wrreq` = 0 the next cycle; the next arbitration starts from req 0.
